inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter: INST_WIDTH, default 8, instruction word width.
REQ-002 Parameter: ADDR_WIDTH, default 4, instruction address width.
REQ-003 Parameter: DEPTH, default 4, prefetch buffer entries (power of two, >= 2).
REQ-004 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 sys_rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 jump_flag  input  1  redirect request from the memory-access stage.
REQ-007 jump_addr  input  ADDR_WIDTH  redirect target address.
REQ-008 imem_rd_en  output  1  instruction memory read strobe.
REQ-009 imem_addr  output  ADDR_WIDTH  instruction memory read address.
REQ-010 imem_rdata  input  INST_WIDTH  memory read data, valid exactly one cycle after imem_rd_en.
REQ-011 inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 inst_ready  input  1  decode stage accepts the head this cycle.
REQ-013 inst  output  INST_WIDTH  head instruction.
REQ-014 inst_addr  output  ADDR_WIDTH  address of head instruction (for jump forwarding).
REQ-015 buf_count  output  clog2(DEPTH)+1  entries currently held.

Function
REQ-016 Internal state: fetch_pc, pending flag (read in flight), pending_addr, FIFO of {inst, addr} pairs, read/write pointers, count.
REQ-017 imem_rd_en SHALL be combinational: sys_rst=1 AND jump_flag=0 AND (count + pending) < DEPTH.
REQ-018 imem_addr SHALL equal fetch_pc at all times.
REQ-019 On a cycle with imem_rd_en=1: fetch_pc <= fetch_pc+1 modulo 2^ADDR_WIDTH (15 wraps to 0); pending <= 1; pending_addr <= fetch_pc.
REQ-020 On a cycle with pending=1 and jump_flag=0: {imem_rdata, pending_addr} SHALL be pushed at the write pointer; pending clears unless a new read issues that cycle.
REQ-021 Pop SHALL occur on a cycle with inst_valid=1 AND inst_ready=1; read pointer advances, count decrements.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; both take effect.
REQ-023 inst_valid SHALL be (count != 0); inst/inst_addr SHALL present the head entry when valid and all zeros when count=0.
REQ-024 Issue gating at REQ-017 SHALL guarantee no push ever occurs when count=DEPTH; no credit is taken from a same-cycle pop.
REQ-025 Jump (jump_flag=1) SHALL take priority over all other events: FIFO flushed (count, pointers <= 0), in-flight read discarded (pending <= 0, its data never pushed), fetch_pc <= jump_addr, no read issued that cycle.
REQ-026 A pop handshake on a jump cycle SHALL be treated as consumed by decode; the buffer is cleared regardless.
REQ-027 First read after a jump SHALL issue in the cycle after jump_flag, at jump_addr; inst_valid SHALL be 0 for the two cycles following the jump cycle.
REQ-028 Throughput: with inst_ready held 1 and no jumps, one instruction SHALL be delivered per cycle in steady state.
REQ-029 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While sys_rst=0 at a rising edge: fetch_pc, pending, pending_addr, pointers, count <= 0; FIFO contents need not be cleared.
REQ-031 During reset: imem_rd_en=0, inst_valid=0, inst=0, inst_addr=0, buf_count=0.
REQ-032 First cycle with sys_rst=1: imem_rd_en=1, imem_addr=0; inst_valid first 1 two cycles later with inst_addr=0.
REQ-033 Reset asserted mid-operation SHALL discard buffer and in-flight read; no push occurs on the reset edge.

Verification
REQ-034 Reset release, ROM[a]=a+0x10, inst_ready=1 -> inst_valid rises cycle 2; inst 0x10,0x11,0x12... one per cycle, inst_addr 0,1,2...
REQ-035 inst_ready=0 held from reset -> buf_count reaches 4, imem_rd_en drops to 0, inst stays 0x10; release ready -> 0x10..0x13 then 0x14 with no gap or duplicate.
REQ-036 Free run past address 15 -> imem_addr wraps 15 to 0; inst_addr sequence 14,15,0,1.
REQ-037 jump_flag=1, jump_addr=9 with buf_count=3 and pending=1 -> next cycle buf_count=0, imem_addr=9; stale data never appears; next delivered inst_addr=9.
REQ-038 jump_flag=1 in the same cycle as a pop and a push -> buffer empty next cycle, count=0, no underflow.
REQ-039 sys_rst=0 for one cycle while buffer full -> all outputs zero next cycle; refetch restarts at address 0.

Source files
------------

// File: rtl/inst_prefetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch_if
//  Description : Bundle of the signals that connect the instruction prefetch
//                buffer to the redirect source, the instruction memory and
//                the decode stage.
//                  jump_flag / jump_addr : redirect request and target
//                  imem_rd_en / imem_addr: memory read strobe and address
//                  imem_rdata            : read data, one cycle after strobe
//                  inst_valid / inst_ready / inst / inst_addr : head handshake
//                  buf_count             : number of buffered entries
//                Modport master is the prefetch unit; modport slave is the
//                surrounding pipeline and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_prefetch_if #(
    parameter int INST_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  jump_flag;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic                  imem_rd_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic [CNT_W-1:0]      buf_count;

    modport master (
        input  jump_flag,
        input  jump_addr,
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_addr,
        output buf_count
    );

    modport slave (
        output jump_flag,
        output jump_addr,
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_addr,
        input  buf_count
    );
endinterface
`default_nettype wire

// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch
//  Description : Instruction prefetch buffer. Streams sequential reads from
//                an instruction memory with one cycle of read latency into a
//                small FIFO of {instruction, address} pairs and presents the
//                head to decode with a valid/ready handshake. A redirect
//                flushes the FIFO, drops the read in flight and restarts
//                fetching at the redirect target.
//  Ports       : sys_clk  - clock, all state updates on its rising edge
//                sys_rst  - synchronous reset, active low
//                bus      - inst_prefetch_if.master (redirect, memory read
//                           port, decode handshake, occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch #(
    parameter int INST_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst,
    inst_prefetch_if.master  bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INST_WIDTH + ADDR_WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fetch_pc_q,     fetch_pc_d;
    logic                  pending_q,      pending_d;
    logic [ADDR_WIDTH-1:0] pending_addr_q, pending_addr_d;
    logic [PTR_W-1:0]      rd_ptr_q,       rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q,       wr_ptr_d;
    logic [CNT_W-1:0]      count_q,        count_d;

    // Entry layout: {instruction, address}
    logic [ENTRY_W-1:0]    fifo_q [DEPTH];

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic                  jump_w;
    logic [CNT_W:0]        inflight_w;
    logic                  issue_w;
    logic                  push_w;
    logic                  pop_w;
    logic                  valid_w;
    logic [ENTRY_W-1:0]    head_w;

    assign jump_w = sys_rst & bus.jump_flag;

    // Entries held plus the read still in flight. A read is only issued
    // when a slot is guaranteed for its data, so the FIFO can never be
    // pushed while full. A same-cycle pop deliberately earns no credit;
    // this keeps the issue path independent of inst_ready.
    assign inflight_w = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
    assign issue_w    = sys_rst & ~bus.jump_flag
                      & (inflight_w < (CNT_W+1)'(DEPTH));

    // Data of the read issued last cycle arrives now; a redirect discards it.
    assign push_w     = sys_rst & ~bus.jump_flag & pending_q;

    // Outputs are forced quiet while reset is held so nothing stale leaks
    // out before the reset edge has cleared the counters.
    assign valid_w    = sys_rst & (count_q != '0);

    // A handshake coinciding with a redirect is taken as consumed, but the
    // flush already clears the pointers, so no pointer update is needed.
    assign pop_w      = valid_w & bus.inst_ready & ~bus.jump_flag;

    assign head_w     = fifo_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_rd_en = issue_w;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = valid_w;
    assign bus.inst       = valid_w ? head_w[ENTRY_W-1:ADDR_WIDTH] : '0;
    assign bus.inst_addr  = valid_w ? head_w[ADDR_WIDTH-1:0]       : '0;
    assign bus.buf_count  = sys_rst ? count_q                      : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        pending_d      = pending_q;
        pending_addr_d = pending_addr_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;

        if (jump_w) begin
            // Redirect wins over every other event in the same cycle.
            fetch_pc_d = bus.jump_addr;
            pending_d  = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue_w) begin
                fetch_pc_d     = fetch_pc_q + ADDR_WIDTH'(1);
                pending_d      = 1'b1;
                pending_addr_d = fetch_pc_q;
            end else if (pending_q) begin
                pending_d      = 1'b0;
            end

            // Pointer widths equal log2(DEPTH), so increments wrap for free.
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push_w, pop_w})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            fetch_pc_q     <= '0;
            pending_q      <= 1'b0;
            pending_addr_q <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            pending_q      <= pending_d;
            pending_addr_q <= pending_addr_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    // FIFO storage has no reset; only entries below count are ever exposed.
    always_ff @(posedge sys_clk) begin
        if (push_w) begin
            fifo_q[wr_ptr_q] <= {bus.imem_rdata, pending_addr_q};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_prefetch
//  Description : Directed self-checking bench for inst_prefetch. A model ROM
//                returns 0x10 + address one cycle after each read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch;

    localparam int INST_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 4;

    logic sys_clk;
    logic sys_rst;

    int n_compared;
    int n_mismatched;

    inst_prefetch_if #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) bus ();

    inst_prefetch #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ROM[a] = 0x10 + a, data valid one cycle after the strobe
    always @(posedge sys_clk) begin
        if (bus.imem_rd_en) begin
            bus.imem_rdata <= INST_WIDTH'(16) + INST_WIDTH'(bus.imem_addr);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        n_compared   = 0;
        n_mismatched = 0;
        sys_rst        = 1'b0;
        bus.jump_flag  = 1'b0;
        bus.jump_addr  = '0;
        bus.inst_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) next_cycle();
        settle();
        check_value("rst_rd_en",  32'(bus.imem_rd_en), 32'd0);
        check_value("rst_valid",  32'(bus.inst_valid), 32'd0);
        check_value("rst_inst",   32'(bus.inst),       32'd0);
        check_value("rst_iaddr",  32'(bus.inst_addr),  32'd0);
        check_value("rst_count",  32'(bus.buf_count),  32'd0);

        // ---------------- release, free run with wrap ----------------
        sys_rst = 1'b1;
        settle();
        check_value("c0_rd_en",   32'(bus.imem_rd_en), 32'd1);
        check_value("c0_addr",    32'(bus.imem_addr),  32'd0);
        check_value("c0_valid",   32'(bus.inst_valid), 32'd0);
        next_cycle(); settle();
        check_value("c1_valid",   32'(bus.inst_valid), 32'd0);
        check_value("c1_inst",    32'(bus.inst),       32'd0);
        check_value("c1_addr",    32'(bus.imem_addr),  32'd1);
        next_cycle(); settle();
        for (int k = 0; k < 20; k++) begin
            check_value("run_valid", 32'(bus.inst_valid), 32'd1);
            check_value("run_inst",  32'(bus.inst),       32'(16 + (k % 16)));
            check_value("run_iaddr", 32'(bus.inst_addr),  32'(k % 16));
            check_value("run_maddr", 32'(bus.imem_addr),  32'((k + 2) % 16));
            check_value("run_count", 32'(bus.buf_count),  32'd1);
            next_cycle(); settle();
        end

        // ---------------- jump together with push and pop ----------------
        bus.jump_flag = 1'b1;
        bus.jump_addr = 4'd2;
        settle();
        check_value("jpp_rd_en",  32'(bus.imem_rd_en), 32'd0);
        check_value("jpp_valid",  32'(bus.inst_valid), 32'd1);
        next_cycle();
        bus.jump_flag = 1'b0;
        settle();
        check_value("jpp1_count", 32'(bus.buf_count),  32'd0);
        check_value("jpp1_valid", 32'(bus.inst_valid), 32'd0);
        check_value("jpp1_addr",  32'(bus.imem_addr),  32'd2);
        check_value("jpp1_rd_en", 32'(bus.imem_rd_en), 32'd1);
        next_cycle(); settle();
        check_value("jpp2_valid", 32'(bus.inst_valid), 32'd0);
        check_value("jpp2_count", 32'(bus.buf_count),  32'd0);
        next_cycle(); settle();
        check_value("jpp3_valid", 32'(bus.inst_valid), 32'd1);
        check_value("jpp3_iaddr", 32'(bus.inst_addr),  32'd2);
        check_value("jpp3_inst",  32'(bus.inst),       32'h12);
        next_cycle(); settle();
        check_value("jpp4_iaddr", 32'(bus.inst_addr),  32'd3);
        check_value("jpp4_inst",  32'(bus.inst),       32'h13);

        // ---------------- jump with 3 buffered + 1 in flight ----------------
        bus.inst_ready = 1'b0;
        sys_rst = 1'b0;
        next_cycle();
        sys_rst = 1'b1;
        settle();
        repeat (4) next_cycle();
        settle();
        check_value("jb_count",   32'(bus.buf_count),  32'd3);
        check_value("jb_rd_en",   32'(bus.imem_rd_en), 32'd0);
        bus.jump_flag = 1'b1;
        bus.jump_addr = 4'd9;
        settle();
        check_value("jb_jrd_en",  32'(bus.imem_rd_en), 32'd0);
        next_cycle();
        bus.jump_flag  = 1'b0;
        bus.inst_ready = 1'b1;
        settle();
        check_value("jb1_count",  32'(bus.buf_count),  32'd0);
        check_value("jb1_addr",   32'(bus.imem_addr),  32'd9);
        check_value("jb1_rd_en",  32'(bus.imem_rd_en), 32'd1);
        check_value("jb1_valid",  32'(bus.inst_valid), 32'd0);
        next_cycle(); settle();
        check_value("jb2_valid",  32'(bus.inst_valid), 32'd0);
        next_cycle(); settle();
        check_value("jb3_valid",  32'(bus.inst_valid), 32'd1);
        check_value("jb3_iaddr",  32'(bus.inst_addr),  32'd9);
        check_value("jb3_inst",   32'(bus.inst),       32'h19);
        next_cycle(); settle();
        check_value("jb4_iaddr",  32'(bus.inst_addr),  32'd10);
        check_value("jb4_inst",   32'(bus.inst),       32'h1A);

        // ---------------- fill with decode stalled ----------------
        bus.inst_ready = 1'b0;
        sys_rst = 1'b0;
        next_cycle();
        sys_rst = 1'b1;
        settle();
        repeat (5) next_cycle();
        settle();
        for (int k = 0; k < 3; k++) begin
            check_value("full_count", 32'(bus.buf_count),  32'd4);
            check_value("full_rd_en", 32'(bus.imem_rd_en), 32'd0);
            check_value("full_inst",  32'(bus.inst),       32'h10);
            check_value("full_maddr", 32'(bus.imem_addr),  32'd4);
            next_cycle(); settle();
        end

        // ---------------- one-cycle reset while full ----------------
        sys_rst = 1'b0;
        settle();
        check_value("mr_rd_en",   32'(bus.imem_rd_en), 32'd0);
        check_value("mr_valid",   32'(bus.inst_valid), 32'd0);
        check_value("mr_count",   32'(bus.buf_count),  32'd0);
        next_cycle();
        sys_rst = 1'b1;
        settle();
        check_value("mr1_count",  32'(bus.buf_count),  32'd0);
        check_value("mr1_valid",  32'(bus.inst_valid), 32'd0);
        check_value("mr1_inst",   32'(bus.inst),       32'd0);
        check_value("mr1_iaddr",  32'(bus.inst_addr),  32'd0);
        check_value("mr1_addr",   32'(bus.imem_addr),  32'd0);
        check_value("mr1_rd_en",  32'(bus.imem_rd_en), 32'd1);
        repeat (6) next_cycle();
        settle();
        check_value("refill_cnt", 32'(bus.buf_count),  32'd4);

        // ---------------- release decode: no gap, no duplicate ----------------
        bus.inst_ready = 1'b1;
        settle();
        for (int k = 0; k < 8; k++) begin
            check_value("rel_valid", 32'(bus.inst_valid), 32'd1);
            check_value("rel_inst",  32'(bus.inst),       32'(16 + k));
            check_value("rel_iaddr", 32'(bus.inst_addr),  32'(k));
            next_cycle(); settle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
